skid_pipe_stage: RTL and testbench
==================================

// Module: skid_pipe_stage
// PURPOSE
//  Elastic pipeline stage between core stages. Two-entry skid buffer with valid/ready handshake on both sides.
//  Drives the per-bit stage flops downstream and takes producer data upstream.
//  Breaks the combinational ready path: in_ready is a register output.
//  A synchronous flush squashes in-flight entries on branch mispredict.
// PARAMETERS
//  WIDTH  64  payload bits per entry (instruction/operand bundle)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = in reset)
//  flush      in   1      synchronous squash of all held entries
//  in_valid   in   1      producer offers in_data
//  in_ready   out  1      stage can accept; registered
//  in_data    in   WIDTH  producer payload
//  out_valid  out  1      out_data valid to consumer
//  out_ready  in   1      consumer accepts this cycle
//  out_data   out  WIDTH  payload presented downstream (main register)
//  occupancy  out  2      entries held: 0, 1 or 2
// BEHAVIOUR
//  Reset (reset==0, async, no clock needed): state EMPTY; out_valid=0; in_ready=1; occupancy=0; out_data=0; skid data=0.
//  Transfers: accept = in_valid & in_ready; drain = out_valid & out_ready; both evaluated at the same rising edge.
//  States, occupancy equals the state code:
//   EMPTY: no entries. Accept -> main<=in_data, go to ONE.
//   ONE: entry in main. Accept & drain -> main<=in_data, stay ONE. Accept only -> skid<=in_data, go to TWO.
//        Drain only -> EMPTY. Neither -> hold.
//   TWO: entries in main and skid; in_ready=0, so no accept. Drain -> main<=skid, go to ONE. Else hold.
//  Outputs: out_valid = (state!=EMPTY); out_data = main; in_ready = (state!=TWO).
//   All three are pure register outputs, with no in->out combinational path.
//  Latency: 1 cycle from accept to out_valid when the stage is empty.
//  Throughput: 1 entry per cycle while out_ready=1.
//  Ordering: strict FIFO. The skid entry never overtakes main.
//  Flush: next edge -> EMPTY, in_ready=1. Flush has priority over any same-cycle accept/drain.
//   The data registers may keep stale contents; out_valid=0 masks them.
//   A drain in the flush cycle still counts as a consumer transfer.
//  Stall: out_valid=1 & out_ready=0 -> out_data and out_valid stay stable until drain (AXI-style).
//  Producer rule: once in_valid=1 it stays high until accepted, unless flush.
//  Reset mid-operation: entries are dropped immediately; no partial transfer completes.
//  Data registers load only on their enables: main_en = (accept & (EMPTY | drain)) | (TWO & drain);
//   skid_en = accept & ONE & ~drain.
//  Illegal state encoding (3) recovers to EMPTY at the next edge.
// STRUCTURE
//  Shared package pipe_pkg:
//   typedef enum logic [1:0] {EMPTY=2'd0, ONE=2'd1, TWO=2'd2} skid_state_e;
//   localparam PIPE_W_DEFAULT = 64.
//  One sub-module, en_dff_bank #(WIDTH): WIDTH-bit register with enable and async active-low clear.
//   Instantiated twice, for main and skid.
//  The control FSM and the enable logic stay inline in skid_pipe_stage.
// TESTING
//  1 Reset: hold reset=0 with in_valid=1 for 3 clocks -> out_valid=0, in_ready=1, occupancy=0, out_data=0.
//  2 Streaming: out_ready=1, push 0x1..0x8 back-to-back -> out_data 0x1..0x8 in order, 1-cycle latency.
//    in_ready stays 1 throughout.
//  3 Backpressure: out_ready=0, push 0xA, 0xB -> occupancy=2, in_ready=0, 0xC held by producer.
//    Then raise out_ready -> outputs 0xA, 0xB, 0xC, no loss, no duplication.
//  4 Simultaneous accept+drain in ONE -> occupancy stays 1, out_data updates to the new word the next cycle.
//  5 Flush: in TWO assert flush together with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1.
//    The word offered in the flush cycle is dropped.
//  6 Async reset: drop reset mid-cycle in TWO -> out_valid=0 before the next clk edge.
//    Also run random valid/ready with a scoreboard for 10k cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the elastic pipeline stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam int PIPE_W_DEFAULT = 64;

endpackage

// File: rtl/en_dff_bank.sv
// WIDTH-bit register bank with load enable
// and asynchronous active-low clear.
module en_dff_bank #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/skid_pipe_stage.sv
// Two-entry skid buffer stage with registered
// in_ready/out_valid and synchronous flush.
module skid_pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_accept;
  logic             w_drain;
  logic             w_main_en;
  logic             w_skid_en;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    unique case (1'b1)
      (r_state == EMPTY): begin
        w_main_en = w_accept;
        if (w_accept) w_state_nxt = ONE;
      end
      (r_state == ONE): begin
        w_main_en = w_accept & w_drain;
        w_skid_en = w_accept & ~w_drain;
        if (w_accept & ~w_drain) begin
          w_state_nxt = TWO;
        end else if (~w_accept & w_drain) begin
          w_state_nxt = EMPTY;
        end
      end
      (r_state == TWO): begin
        w_main_en = w_drain;
        if (w_drain) w_state_nxt = ONE;
      end
      default: w_state_nxt = EMPTY;
    endcase
    // Squash wins over any same-edge accept/drain
    if (flush) w_state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != TWO);
      r_out_valid <= (w_state_nxt != EMPTY);
    end
  end

  assign w_main_d = (r_state == TWO) ? w_skid_q : in_data;

  en_dff_bank #(
    .WIDTH (WIDTH)
  ) u_main (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  en_dff_bank #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_skid_en),
    .i_d   (in_data),
    .o_q   (w_skid_q)
  );

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = w_main_q;
  assign occupancy = r_state;

endmodule

// File: tb/tb_skid_pipe_stage.sv
// Bench for skid_pipe_stage: directed steps plus
// random traffic against a FIFO queue model.
module tb_skid_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [1:0]  occupancy;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] q[$];

  skid_pipe_stage #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid),
        64'(q.size() != 0));
    chk({tag, ".in_ready"}, 64'(in_ready),
        64'(q.size() < 2));
    chk({tag, ".occupancy"}, 64'(occupancy),
        64'(q.size()));
    if (q.size() != 0)
      chk({tag, ".out_data"}, out_data, q[0]);
  endtask

  // Drive one cycle, advance the queue model, then compare.
  task automatic step(input logic v, input logic [63:0] d,
                      input logic r, input logic f,
                      input string tag, output logic acc);
    logic drn;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    acc = v && (q.size() < 2);
    drn = r && (q.size() != 0);
    @(posedge clk);
    #1;
    if (f) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    cmp_model(tag);
  endtask

  initial begin
    logic        acc;
    logic        pv;
    logic [63:0] pd;

    // Reset held with a pending producer word
    reset = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_data = 64'h123;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.occupancy", 64'(occupancy), 64'd0);
    chk("rst.out_data", out_data, 64'd0);
    reset = 1'b1;

    // Streaming with 1-cycle latency
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 64'(i), 1'b1, 1'b0, "stream", acc);
      chk("stream.word", out_data, 64'(i));
      chk("stream.rdy", 64'(in_ready), 64'd1);
    end
    step(1'b0, 64'd0, 1'b1, 1'b0, "stream.tail", acc);

    // Backpressure fills both entries
    step(1'b1, 64'hA, 1'b0, 1'b0, "bp.a", acc);
    step(1'b1, 64'hB, 1'b0, 1'b0, "bp.b", acc);
    chk("bp.occ2", 64'(occupancy), 64'd2);
    chk("bp.rdy0", 64'(in_ready), 64'd0);
    step(1'b1, 64'hC, 1'b0, 1'b0, "bp.hold", acc);
    chk("bp.c_not_taken", 64'(acc), 64'd0);
    chk("bp.out_a", out_data, 64'hA);
    step(1'b1, 64'hC, 1'b1, 1'b0, "bp.d_a", acc);
    chk("bp.out_b", out_data, 64'hB);
    step(1'b1, 64'hC, 1'b1, 1'b0, "bp.d_b", acc);
    chk("bp.out_c", out_data, 64'hC);

    // Accept and drain together in ONE
    step(1'b1, 64'hD, 1'b1, 1'b0, "ad", acc);
    chk("ad.occ", 64'(occupancy), 64'd1);
    chk("ad.word", out_data, 64'hD);
    step(1'b0, 64'd0, 1'b1, 1'b0, "ad.tail", acc);
    chk("ad.empty", 64'(out_valid), 64'd0);

    // Flush from TWO drops the offered word
    step(1'b1, 64'h51, 1'b0, 1'b0, "fl.a", acc);
    step(1'b1, 64'h52, 1'b0, 1'b0, "fl.b", acc);
    step(1'b1, 64'h53, 1'b1, 1'b1, "fl", acc);
    chk("fl.valid", 64'(out_valid), 64'd0);
    chk("fl.occ", 64'(occupancy), 64'd0);
    chk("fl.rdy", 64'(in_ready), 64'd1);
    step(1'b0, 64'd0, 1'b0, 1'b0, "fl.idle", acc);

    // Asynchronous reset in the middle of a cycle
    step(1'b1, 64'hA1, 1'b0, 1'b0, "ar.a", acc);
    step(1'b1, 64'hA2, 1'b0, 1'b0, "ar.b", acc);
    #3 reset = 1'b0;
    #1;
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.rdy", 64'(in_ready), 64'd1);
    chk("ar.occ", 64'(occupancy), 64'd0);
    chk("ar.data", out_data, 64'd0);
    q.delete();
    @(posedge clk);
    #2 reset = 1'b1;

    // Random traffic, producer holds its word until taken
    pv = 1'b0;
    pd = '0;
    for (int n = 0; n < 10000; n++) begin
      if (!pv && ($urandom % 4 != 0)) begin
        pv = 1'b1;
        pd = {$urandom, $urandom};
      end
      step(pv, pd, ($urandom % 3) != 0,
           ($urandom % 64) == 0, "rnd", acc);
      if (acc || flush) pv = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
